// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and RV32I opcode constants for decode_stage
// Contents: instr_type_e class codes, opcode constants, decoded_t buffer entry.
// decoded_t operand/imm/pc fields are MAX_W wide; the top narrows them to XLEN/PC_W.
package decode_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    T_R       = 3'd0,
    T_I       = 3'd1,
    T_S       = 3'd2,
    T_B       = 3'd3,
    T_U       = 3'd4,
    T_J       = 3'd5,
    T_ILLEGAL = 3'd6
  } instr_type_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    instr_type_e      itype;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [MAX_W-1:0] rs1_data;
    logic [MAX_W-1:0] rs2_data;
    logic [MAX_W-1:0] imm;
    logic [MAX_W-1:0] pc;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - DEPTH-entry FIFO of decoded_t entries with flush
// Ports: clk, rst (async, active-high), flush (sync, clears pointers/count),
//        push/push_data (write tail), pop (advance head), head (entry at read
//        pointer), count (occupancy). Caller never pushes when full or pops when empty.
module decode_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  decoded_t                   push_data,
  input  logic                       pop,
  output decoded_t                   head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  decoded_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with buffered, flushable output
// Inputs : clk, rst (async active-high), flush, in_valid, in_instruction, in_pc,
//          rs1_read_data/rs2_read_data (same-cycle regfile data), out_ready.
// Outputs: in_ready, rs1_addr/rs2_addr, out_valid, out_type, out_opcode,
//          out_funct3, out_funct7, out_rd, out_rs1_data, out_rs2_data, out_imm,
//          out_pc, out_illegal, decoded_count (pops since reset).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [PC_W-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_read_data,
  input  logic [XLEN-1:0] rs2_read_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_type,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal,
  output logic [31:0]     decoded_count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [6:0]       w_opcode;
  logic             w_sign;
  instr_type_e      w_type;
  logic [MAX_W-1:0] w_imm;
  decoded_t         w_entry;
  decoded_t         w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      r_decoded_count;

  assign w_opcode = in_instruction[6:0];
  assign w_sign   = in_instruction[31];
  assign rs1_addr = in_instruction[19:15];
  assign rs2_addr = in_instruction[24:20];

  always_comb begin
    w_type = T_ILLEGAL;
    if (in_instruction[1:0] == 2'b11) begin
      case (w_opcode)
        OP_OP:                                        w_type = T_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: w_type = T_I;
        OP_STORE:                                     w_type = T_S;
        OP_BRANCH:                                    w_type = T_B;
        OP_LUI, OP_AUIPC:                             w_type = T_U;
        OP_JAL:                                       w_type = T_J;
        default:                                      w_type = T_ILLEGAL;
      endcase
    end
  end

  // Immediates are built at full MAX_W sign extension; narrowing to XLEN later
  // keeps the correct sign extension for either datapath width.
  always_comb begin
    w_imm = '0;
    case (w_type)
      T_I: w_imm = {{(MAX_W-12){w_sign}}, in_instruction[31:20]};
      T_S: w_imm = {{(MAX_W-12){w_sign}}, in_instruction[31:25], in_instruction[11:7]};
      T_B: w_imm = {{(MAX_W-13){w_sign}}, in_instruction[31], in_instruction[7],
                    in_instruction[30:25], in_instruction[11:8], 1'b0};
      T_U: w_imm = {{(MAX_W-32){w_sign}}, in_instruction[31:12], 12'b0};
      T_J: w_imm = {{(MAX_W-21){w_sign}}, in_instruction[31], in_instruction[19:12],
                    in_instruction[20], in_instruction[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Operands are captured at accept; formats without a source register carry 0.
  always_comb begin
    w_entry          = '0;
    w_entry.itype    = w_type;
    w_entry.opcode   = w_opcode;
    w_entry.funct3   = in_instruction[14:12];
    w_entry.funct7   = in_instruction[31:25];
    w_entry.rd       = (w_type inside {T_S, T_B, T_ILLEGAL}) ? 5'd0 : in_instruction[11:7];
    w_entry.rs1_data = (w_type inside {T_U, T_J, T_ILLEGAL}) ? '0 : MAX_W'(rs1_read_data);
    w_entry.rs2_data = (w_type inside {T_R, T_S, T_B}) ? MAX_W'(rs2_read_data) : '0;
    w_entry.imm      = w_imm;
    w_entry.pc       = MAX_W'(in_pc);
    w_entry.illegal  = (w_type == T_ILLEGAL);
  end

  // Readiness depends only on occupancy, flush and reset, never on out_ready.
  assign in_ready  = ~rst & ~flush & (w_count < CNT_W'(DEPTH));
  assign out_valid = (w_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  decode_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  // A pop in a flush cycle is discarded and therefore not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decoded_count <= '0;
    end else if (w_pop && !flush) begin
      r_decoded_count <= r_decoded_count + 32'd1;
    end
  end

  assign decoded_count = r_decoded_count;
  assign out_type      = w_head.itype;
  assign out_opcode    = w_head.opcode;
  assign out_funct3    = w_head.funct3;
  assign out_funct7    = w_head.funct7;
  assign out_rd        = w_head.rd;
  assign out_rs1_data  = XLEN'(w_head.rs1_data);
  assign out_rs2_data  = XLEN'(w_head.rs2_data);
  assign out_imm       = XLEN'(w_head.imm);
  assign out_pc        = PC_W'(w_head.pc);
  assign out_illegal   = w_head.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter DEPTH, 2, output buffer entries; power of two, 2 to 8.
REQ-003 Parameter PC_W, 32, program-counter width.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 flush  in  1  synchronous pipeline flush.
REQ-008 in_valid  in  1  fetch presents an instruction.
REQ-009 in_ready  out  1  stage accepts the presented instruction this cycle.
REQ-010 in_instruction  in  32  raw RV32I instruction word.
REQ-011 in_pc  in  PC_W  address of in_instruction.
REQ-012 rs1_addr / rs2_addr  out  5 each  regfile read addresses: in_instruction[19:15] and [24:20], combinational.
REQ-013 rs1_read_data / rs2_read_data  in  XLEN each  regfile read data for the current rs1_addr/rs2_addr, same cycle.
REQ-014 out_valid  in:no, out  1  buffer head holds a decoded instruction.
REQ-015 out_ready  in  1  execute consumes the head this cycle.
REQ-016 out_type  out  3  class code R, I, S, B, U, J or ILLEGAL.
REQ-017 out_opcode / out_funct3 / out_funct7  out  7 / 3 / 7  raw fields of the head entry.
REQ-018 out_rd  out  5  destination register, 0 for S, B and ILLEGAL.
REQ-019 out_rs1_data / out_rs2_data / out_imm  out  XLEN each  operands and sign-extended immediate.
REQ-020 out_pc  out  PC_W  head PC.
REQ-021 out_illegal  out  1  head is an illegal encoding.
REQ-022 decoded_count  out  32  count of entries popped since reset.

Function
REQ-023 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-024 in_ready = (count < DEPTH) & ~flush; it has no combinational path from out_ready.
REQ-025 out_valid = (count != 0); the head payload stays stable while out_valid & ~out_ready.
REQ-026 Latency: an instruction accepted into an empty buffer appears at the head on the next cycle.
REQ-027 Opcode classes: 0110011 is R; 0010011, 0000011, 1100111, 1110011 and 0001111 are I; 0100011 is S; 1100011 is B; 0110111 and 0010111 are U; 1101111 is J.
REQ-028 Any other opcode, or instruction[1:0] != 2'b11, gives ILLEGAL with out_illegal = 1 and out_imm = 0.
REQ-029 Immediates are formed per the RV32I I/S/B/U/J formats and sign-extended from instruction[31] to XLEN; B and J have bit0 = 0; U is instruction[31:12] << 12; R gives 0.
REQ-030 Operand capture happens at accept: rs1 data is forced 0 for U, J and ILLEGAL; rs2 data is forced 0 for I, U, J and ILLEGAL.
REQ-031 Simultaneous accept and pop leave count unchanged; an accept when full is impossible per REQ-024.
REQ-032 Pointers wrap modulo DEPTH.
REQ-033 Flush has priority: on the next edge count, both pointers and out_valid go to 0, and any same-cycle accept or pop is discarded.
REQ-034 decoded_count increments on each pop, and on a pop in a flush cycle it does not increment.
REQ-035 decoded_count wraps from 0xFFFFFFFF to 0.

Reset
REQ-036 Asserting rst immediately clears count, pointers, out_valid, decoded_count and all buffer payload to 0, and mid-transfer entries are lost.
REQ-037 While rst is high in_ready is 0; the first accept is possible on the first edge after rst deasserts.

Structure
REQ-038 Package decode_pkg holds the instr_type enum, RV32I opcode constants and the decoded-entry struct (type, fields, rd, operands, imm, pc, illegal).
REQ-039 Sub-module decode_buffer is a parametrised DEPTH-entry FIFO of decoded-entry structs with count, pointers and flush.
REQ-040 Decode and immediate generation are combinational logic in decode_stage.

Verification
REQ-041 Stimulus: in_instruction 0x00106093 (ori x1,x0,1), rs1_read_data 0x55 -> next cycle out_type I, rd 1, imm 1, funct3 110, rs1_data 0x55, rs2_data 0.
REQ-042 Stimulus: 0x00102023 (sw) then 0x00418063 (beq) with out_ready = 1 -> first S, imm 0, rd 0; then B, imm 0; decoded_count = 2.
REQ-043 Stimulus: 0xFFDFF0EF (jal x1,-4) with XLEN = 64 -> J, rd 1, imm 0xFFFFFFFFFFFFFFFC, rs1_data 0.
REQ-044 Stimulus: 0xFFFFFFFF, then 0x00000013 with bits[1:0] changed to 00 -> both ILLEGAL, out_illegal = 1, imm 0.
REQ-045 Stimulus: out_ready = 0 and 3 valid instructions at DEPTH = 2 -> in_ready drops after 2 accepts and the head is unchanged; with flush on the next cycle, out_valid = 0 and decoded_count is unchanged.
REQ-046 Stimulus: rst pulsed while the buffer is full -> out_valid = 0 and decoded_count = 0 immediately, with no clock edge needed.
